// File: rtl/bidir_bus_master.sv
// ----------------------------------------------------------------------------
// bidir_bus_master
//
// Transaction sequencer for the pin side of a 14-bit address / 8-bit data
// bidirectional bus. It accepts one read or write request at a time and turns
// it into registered pin activity for the pad wrappers: direction control,
// active-low strobes and read-data sampling. After a write the bus is left
// released for TURN_CYCLES so the FPGA and the device never drive data
// together.
//
// Sequence: IDLE -> SETUP -> STROBE -> HOLD -> (write: TURN | read: IDLE).
//
// Parameters
//   SETUP_CYCLES   0..15  address/data setup before the strobe (0 skips SETUP)
//   STROBE_CYCLES  1..15  strobe low width
//   TURN_CYCLES    0..15  released-bus cycles after a write
//
// Ports
//   clk, rst_n             clock; synchronous active-low reset
//   req_valid/req_ready    request handshake (accept when both high)
//   req_write              1 = write, 0 = read
//   req_addr, req_wdata    request address and write data
//   rsp_valid              one-cycle pulse when read data is valid
//   rsp_rdata              last read data, held until the next read completes
//   addr_o, addr_dir       address pad outputs and direction (1 = drive)
//   data_o, data_dir       data pad outputs and direction (1 = drive)
//   data_i                 data pad inputs
//   rd_n, wr_n             active-low read / write strobes
//
// Optional feature (macro BIDIR_BUS_COUNTERS_EN):
//   adds rd_count / wr_count, saturating 16-bit transaction counters that
//   advance in HOLD of each read / write and clear on reset.
// ----------------------------------------------------------------------------
module bidir_bus_master #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned TURN_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [13:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [13:0] addr_o,
  output logic        addr_dir,
  output logic [7:0]  data_o,
  input  logic [7:0]  data_i,
  output logic        data_dir,
  output logic        rd_n,
  output logic        wr_n
`ifdef BIDIR_BUS_COUNTERS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_TURN
  } state_e;

  // Counter load values: each timed state lasts (load + 1) cycles.
  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] TURN_LD   = 4'(TURN_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [13:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;

  // Pin-side registers, computed from the state being entered.
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [13:0] addr_o_q, addr_o_d;
  logic        addr_dir_q, addr_dir_d;
  logic [7:0]  data_o_q, data_o_d;
  logic        data_dir_q, data_dir_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // ready_q is high only in IDLE, and stays low for the first cycle
        // after reset.
        if (req_valid && ready_q) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (SETUP_CYCLES == 0) begin
            state_d = S_STROBE;
            cnt_d   = STROBE_LD;
          end else begin
            state_d = S_SETUP;
            cnt_d   = SETUP_LD;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = S_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_HOLD;
          // Read data is captured on the edge that ends the last strobe cycle.
          if (!write_q) begin
            rdata_d     = data_i;
            rsp_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        if (write_q && (TURN_CYCLES != 0)) begin
          state_d = S_TURN;
          cnt_d   = TURN_LD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TURN: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pins take the values of the state being entered, so every pin is a
    // flop output with no combinational path from req_*.
    ready_d    = (state_d == S_IDLE);
    addr_o_d   = addr_o_q;
    data_o_d   = data_o_q;
    addr_dir_d = 1'b0;
    data_dir_d = 1'b0;
    rd_n_d     = 1'b1;
    wr_n_d     = 1'b1;
    case (state_d)
      S_SETUP, S_STROBE, S_HOLD: begin
        addr_dir_d = 1'b1;
        addr_o_d   = addr_d;
        data_dir_d = write_d;
        if (write_d) data_o_d = wdata_d;
        if (state_d == S_STROBE) begin
          rd_n_d = write_d;
          wr_n_d = !write_d;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      addr_q      <= 14'd0;
      wdata_q     <= 8'd0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 8'd0;
      addr_o_q    <= 14'd0;
      addr_dir_q  <= 1'b0;
      data_o_q    <= 8'd0;
      data_dir_q  <= 1'b0;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      addr_o_q    <= addr_o_d;
      addr_dir_q  <= addr_dir_d;
      data_o_q    <= data_o_d;
      data_dir_q  <= data_dir_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign addr_o    = addr_o_q;
  assign addr_dir  = addr_dir_q;
  assign data_o    = data_o_q;
  assign data_dir  = data_dir_q;
  assign rd_n      = rd_n_q;
  assign wr_n      = wr_n_q;

`ifdef BIDIR_BUS_COUNTERS_EN
  logic [15:0] rd_count_q, wr_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_count_q <= 16'd0;
      wr_count_q <= 16'd0;
    end else if (state_q == S_HOLD) begin
      if (write_q) begin
        if (wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
      end else begin
        if (rd_count_q != 16'hFFFF) rd_count_q <= rd_count_q + 16'd1;
      end
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule
